// File: rtl/chi_req_responder.sv
// CHI REQ-channel target: grants REQ L-credits, queues requests and answers each with Comp / CompDBIDResp.
// Optional build macro CHI_RSP_TGTID_CHECK_EN: requests whose TgtID is not this node get RespErr NDERR.
module chi_req_responder #(
  parameter logic [10:0] MY_NODE_ID = 11'd1,
  parameter int unsigned DEPTH      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         RX_REQFLITPEND,
  input  logic         RX_REQFLITV,
  input  logic [153:0] RX_REQFLIT,
  output logic         RX_REQLCRDV,
  output logic         TX_RSPFLITPEND,
  output logic         TX_RSPFLITV,
  output logic [72:0]  TX_RSPFLIT,
  input  logic         TX_RSPLCRDV,
  output logic         PROTO_ERR
);
  localparam int unsigned   PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_e;

  typedef struct packed {
    logic [3:0]  qos;
    logic [10:0] src;
    logic [11:0] txn;
    logic        wr;
    logic        nderr;
  } ent_t;

  state_e        state_q, state_d;
  logic [3:0]    init_cnt_q, init_cnt_d;
  logic [3:0]    out_q, out_d;
  logic [3:0]    owed_q, owed_d;
  logic [3:0]    occ_q, occ_d;
  logic [3:0]    rsp_crd_q, rsp_crd_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [11:0]   dbid_q, dbid_d;
  logic          lcrdv_q, lcrdv_d, rspv_q, rspv_d, perr_q, perr_d;
  logic [72:0]   rsp_q, rsp_d;
  ent_t          mem_q [1<<PW];

  logic [6:0] req_op;
  logic       nderr_in;
  ent_t       in_ent, head;
  logic       accept, push, pop, ret, grant, run_grant;

  assign req_op = RX_REQFLIT[68:62];

`ifdef CHI_RSP_TGTID_CHECK_EN
  assign nderr_in = (RX_REQFLIT[14:4] != MY_NODE_ID);
  logic unused_ok;
  assign unused_ok = ^{RX_REQFLITPEND, RX_REQFLIT[153:69], RX_REQFLIT[61:38]};
`else
  assign nderr_in = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{RX_REQFLITPEND, RX_REQFLIT[153:69], RX_REQFLIT[61:38], RX_REQFLIT[14:4]};
`endif

  assign in_ent = '{qos: RX_REQFLIT[3:0], src: RX_REQFLIT[25:15], txn: RX_REQFLIT[37:26],
                    wr: (req_op[6:3] == 4'b0011), nderr: nderr_in};
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dbid_d     = dbid_q;
    rsp_crd_d  = rsp_crd_q;
    perr_d     = perr_q;
    rsp_d      = '0;
    grant      = 1'b0;
    run_grant  = 1'b0;
    accept     = RX_REQFLITV && (out_q != 4'd0);
    push       = accept && (req_op != 7'h00);
    ret        = accept && (req_op == 7'h00);
    pop        = (occ_q != 4'd0) && (rsp_crd_q != 4'd0);

    case (state_q)
      S_INIT: begin
        grant      = 1'b1;
        init_cnt_d = init_cnt_q + 4'd1;
        if (init_cnt_q == DEPTH_C - 4'd1) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end
      end
      default: begin
        grant     = (owed_q != 4'd0);
        run_grant = grant;
      end
    endcase

    // A flit with no credit outstanding is dropped, never queued.
    if (RX_REQFLITV && (out_q == 4'd0)) perr_d = 1'b1;

    out_d  = out_q + {3'b0, grant} - {3'b0, accept};
    owed_d = owed_q + {3'b0, pop} + {3'b0, ret} - {3'b0, run_grant};
    occ_d  = occ_q + {3'b0, push} - {3'b0, pop};

    if (TX_RSPLCRDV && !pop) begin
      if (rsp_crd_q == 4'hF) perr_d = 1'b1;
      else                   rsp_crd_d = rsp_crd_q + 4'd1;
    end else if (!TX_RSPLCRDV && pop) begin
      rsp_crd_d = rsp_crd_q - 4'd1;
    end

    if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d       = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
      rsp_d[3:0]     = head.qos;
      rsp_d[14:4]    = head.src;
      rsp_d[25:15]   = MY_NODE_ID;
      rsp_d[37:26]   = head.txn;
      rsp_d[42:38]   = head.wr ? 5'h05 : 5'h04;
      rsp_d[44:43]   = head.nderr ? 2'b11 : 2'b00;
      if (head.wr) begin
        rsp_d[65:54] = dbid_q;
        dbid_d       = dbid_q + 12'd1;
      end
    end

    lcrdv_d = grant;
    rspv_d  = pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      out_q      <= '0;
      owed_q     <= '0;
      occ_q      <= '0;
      rsp_crd_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dbid_q     <= '0;
      lcrdv_q    <= 1'b0;
      rspv_q     <= 1'b0;
      perr_q     <= 1'b0;
      rsp_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      out_q      <= out_d;
      owed_q     <= owed_d;
      occ_q      <= occ_d;
      rsp_crd_q  <= rsp_crd_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dbid_q     <= dbid_d;
      lcrdv_q    <= lcrdv_d;
      rspv_q     <= rspv_d;
      perr_q     <= perr_d;
      rsp_q      <= rsp_d;
    end
  end

  // Payload storage needs no reset; occupancy and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_ent;
  end

  assign RX_REQLCRDV    = lcrdv_q & ~rst;
  assign TX_RSPFLITPEND = (occ_q != 4'd0) & ~rst;
  assign TX_RSPFLITV    = rspv_q & ~rst;
  assign TX_RSPFLIT     = rst ? '0 : rsp_q;
  assign PROTO_ERR      = perr_q & ~rst;
endmodule

// File: tb/tb_chi_req_responder.sv
// Self-checking bench for chi_req_responder: directed table, multi-cycle sequences and
// randomized traffic against a transaction-level scoreboard.
module tb_chi_req_responder;
  localparam int DEPTH = 4;
`ifdef CHI_RSP_TGTID_CHECK_EN
  localparam bit         CHK_TGT = 1'b1;
  localparam logic [1:0] ERR_MIS = 2'b11;
`else
  localparam bit         CHK_TGT = 1'b0;
  localparam logic [1:0] ERR_MIS = 2'b00;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         RX_REQFLITPEND = 1'b0;
  logic         RX_REQFLITV = 1'b0;
  logic [153:0] RX_REQFLIT = '0;
  logic         RX_REQLCRDV;
  logic         TX_RSPFLITPEND;
  logic         TX_RSPFLITV;
  logic [72:0]  TX_RSPFLIT;
  logic         TX_RSPLCRDV = 1'b0;
  logic         PROTO_ERR;

  chi_req_responder dut (
    .clk(clk), .rst(rst), .RX_REQFLITPEND(RX_REQFLITPEND), .RX_REQFLITV(RX_REQFLITV),
    .RX_REQFLIT(RX_REQFLIT), .RX_REQLCRDV(RX_REQLCRDV), .TX_RSPFLITPEND(TX_RSPFLITPEND),
    .TX_RSPFLITV(TX_RSPFLITV), .TX_RSPFLIT(TX_RSPFLIT), .TX_RSPLCRDV(TX_RSPLCRDV),
    .PROTO_ERR(PROTO_ERR)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int crd_held, rsp_avail, n_enq, n_rsp, lc_cnt, v_cnt, cyc_n = 0;
  bit exp_perr, got_rsp;
  logic [11:0] model_dbid;
  logic [72:0] last_rsp;
  logic [72:0] exp_q[$];
  logic [11:0] seen_dbid[$];
  int          v_cycles[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [153:0] mkreq(input logic [6:0] op, input logic [10:0] src,
                                         input logic [11:0] txn, input logic [3:0] qos,
                                         input logic [10:0] tgt);
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    t[3:0] = qos; t[14:4] = tgt; t[25:15] = src; t[37:26] = txn; t[68:62] = op;
    return t[153:0];
  endfunction

  // Expected response straight from the field rules; DBIDs are handed out in arrival order.
  function automatic logic [72:0] model(input logic [153:0] f, input logic [11:0] dbid);
    logic [72:0] r;
    int op;
    bit wr;
    op = int'(f[68:62]);
    wr = (op >= 'h18) && (op <= 'h1F);
    r = '0;
    r[3:0]   = f[3:0];
    r[14:4]  = f[25:15];
    r[25:15] = 11'd1;
    r[37:26] = f[37:26];
    r[42:38] = wr ? 5'h05 : 5'h04;
    r[44:43] = (CHK_TGT && f[14:4] != 11'd1) ? 2'b11 : 2'b00;
    r[65:54] = wr ? dbid : 12'h000;
    return r;
  endfunction

  task automatic cyc(input bit fv, input logic [153:0] f, input bit rc);
    RX_REQFLITV = fv; RX_REQFLIT = f; TX_RSPLCRDV = rc;
    if (fv) begin
      if (crd_held == 0) exp_perr = 1'b1;
      else begin
        crd_held--;
        if (f[68:62] != 7'h00) begin
          exp_q.push_back(model(f, model_dbid));
          if (f[68:62] >= 7'h18 && f[68:62] <= 7'h1F) model_dbid = 12'((int'(model_dbid) + 1) % 4096);
          n_enq++;
        end
      end
    end
    if (rc) rsp_avail++;
    @(posedge clk); #1;
    cyc_n++;
    RX_REQFLITV = 1'b0; TX_RSPLCRDV = 1'b0;
    if (RX_REQLCRDV) begin crd_held++; lc_cnt++; end
    if (TX_RSPFLITV) begin
      if (exp_q.size() == 0 || rsp_avail == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_rsp: got %0h expected none (queued=%0d credits=%0d)",
                 TX_RSPFLIT, exp_q.size(), rsp_avail);
      end else begin
        chk("rsp_flit", 128'(TX_RSPFLIT), 128'(exp_q.pop_front()));
        rsp_avail--;
      end
      n_rsp++; v_cnt++; got_rsp = 1'b1; last_rsp = TX_RSPFLIT;
      seen_dbid.push_back(TX_RSPFLIT[65:54]);
      v_cycles.push_back(cyc_n);
    end
    chk("rsp_pend", 128'(TX_RSPFLITPEND), 128'(n_enq != n_rsp));
    chk("proto_err", 128'(PROTO_ERR), 128'(exp_perr));
    chk("lcrd_bound", 128'(crd_held <= DEPTH), 128'(1));
  endtask

  task automatic do_reset();
    logic [5:0] pat;
    rst = 1'b1; RX_REQFLITV = 1'b0; TX_RSPLCRDV = 1'b0; RX_REQFLIT = '0;
    repeat (3) begin
      @(posedge clk); #1;
      cyc_n++;
      chk("rst_outs", 128'({RX_REQLCRDV, TX_RSPFLITPEND, TX_RSPFLITV, TX_RSPFLIT, PROTO_ERR}), 128'(0));
    end
    exp_q.delete(); seen_dbid.delete(); v_cycles.delete();
    crd_held = 0; rsp_avail = 0; n_enq = 0; n_rsp = 0; exp_perr = 1'b0; model_dbid = '0;
    rst = 1'b0;
    pat = '0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b0);
      pat = {pat[4:0], RX_REQLCRDV};
    end
    chk("init_grants", 128'(pat), 128'(6'b111100));
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [10:0] src;
    logic [11:0] txn;
    logic [3:0]  qos;
    logic [10:0] tgt;
    logic [4:0]  exp_opc;
    logic [1:0]  exp_err;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    int k, sent;
    logic [153:0] f;
    vt[0] = '{7'h1D, 11'd5,     12'h02A, 4'h0, 11'd1, 5'h05, 2'b00};
    vt[1] = '{7'h18, 11'd7,     12'h001, 4'h3, 11'd1, 5'h05, 2'b00};
    vt[2] = '{7'h1F, 11'h7FF,   12'hFFF, 4'hF, 11'd1, 5'h05, 2'b00};
    vt[3] = '{7'h17, 11'd2,     12'h010, 4'h1, 11'd1, 5'h04, 2'b00};
    vt[4] = '{7'h20, 11'd3,     12'h011, 4'h2, 11'd1, 5'h04, 2'b00};
    vt[5] = '{7'h01, 11'd4,     12'h012, 4'h0, 11'd3, 5'h04, ERR_MIS};
    vt[6] = '{7'h04, 11'd9,     12'h055, 4'h5, 11'd3, 5'h04, ERR_MIS};
    vt[7] = '{7'h1A, 11'd6,     12'h066, 4'h0, 11'd3, 5'h05, ERR_MIS};

    // Reset, then first-write latency and credit return after the pop.
    do_reset();
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);
    lc_cnt = 0;
    cyc(1'b1, mkreq(7'h1D, 11'd5, 12'h02A, 4'h0, 11'd1), 1'b0);
    chk("t1_v", 128'(TX_RSPFLITV), 128'(0));
    chk("t1_pend", 128'(TX_RSPFLITPEND), 128'(1));
    cyc(1'b0, '0, 1'b0);
    chk("t2_v", 128'(TX_RSPFLITV), 128'(1));
    chk("t2_opc", 128'(TX_RSPFLIT[42:38]), 128'(5'h05));
    chk("t2_tgt", 128'(TX_RSPFLIT[14:4]), 128'(5));
    chk("t2_txn", 128'(TX_RSPFLIT[37:26]), 128'(12'h02A));
    chk("t2_dbid", 128'(TX_RSPFLIT[65:54]), 128'(0));
    repeat (3) cyc(1'b0, '0, 1'b0);
    chk("lcrd_after_pop", 128'(lc_cnt), 128'(1));

    // No RSP credits: queue fills, 5th flit is a protocol error, then drain in order.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, mkreq(7'h18 + 7'(i), 11'(i + 1), 12'(i), 4'(i), 11'd1), 1'b0);
    lc_cnt = 0; v_cnt = 0;
    repeat (4) cyc(1'b0, '0, 1'b0);
    chk("full_lcrd", 128'(lc_cnt), 128'(0));
    chk("full_v", 128'(v_cnt), 128'(0));
    cyc(1'b1, mkreq(7'h01, 11'd9, 12'h099, 4'h0, 11'd1), 1'b0);
    chk("fifth_perr", 128'(PROTO_ERR), 128'(1));
    v_cycles.delete(); lc_cnt = 0;
    repeat (4) cyc(1'b0, '0, 1'b1);
    repeat (6) cyc(1'b0, '0, 1'b0);
    chk("drain_cnt", 128'(v_cycles.size()), 128'(4));
    if (v_cycles.size() == 4) chk("drain_b2b", 128'(v_cycles[3] - v_cycles[0]), 128'(3));
    chk("drain_lcrd", 128'(lc_cnt), 128'(4));

    // Directed table.
    do_reset();
    foreach (vt[i]) begin
      k = 0;
      while (crd_held == 0 && k < 10) begin cyc(1'b0, '0, 1'b0); k++; end
      got_rsp = 1'b0;
      cyc(1'b1, mkreq(vt[i].op, vt[i].src, vt[i].txn, vt[i].qos, vt[i].tgt), 1'b1);
      k = 0;
      while (!got_rsp && k < 6) begin cyc(1'b0, '0, 1'b0); k++; end
      if (!got_rsp) begin
        n_chk++; n_err++;
        $display("FAIL vec%0d_timeout: got no rsp expected one", i);
      end else begin
        chk($sformatf("vec%0d_opc", i), 128'(last_rsp[42:38]), 128'(vt[i].exp_opc));
        chk($sformatf("vec%0d_err", i), 128'(last_rsp[44:43]), 128'(vt[i].exp_err));
        chk($sformatf("vec%0d_tgt", i), 128'(last_rsp[14:4]), 128'(vt[i].src));
        chk($sformatf("vec%0d_txn", i), 128'(last_rsp[37:26]), 128'(vt[i].txn));
        chk($sformatf("vec%0d_qos", i), 128'(last_rsp[3:0]), 128'(vt[i].qos));
      end
    end

    // Reset with three requests queued: nothing comes out afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, mkreq(7'h1C, 11'd2, 12'(i), 4'h0, 11'd1), 1'b0);
    do_reset();
    v_cnt = 0;
    repeat (3) cyc(1'b0, '0, 1'b1);
    repeat (5) cyc(1'b0, '0, 1'b0);
    chk("midrst_no_rsp", 128'(v_cnt), 128'(0));
    chk("midrst_crd", 128'(crd_held), 128'(DEPTH));

    // 4097 writes: DBID wraps, then a credit-return request.
    do_reset();
    sent = 0; k = 0;
    while ((sent < 4097 || exp_q.size() != 0) && k < 20000) begin
      if (crd_held > 0 && sent < 4097) begin
        cyc(1'b1, mkreq(7'h18 + 7'($urandom_range(0, 7)), 11'd8, 12'(sent), 4'h0, 11'd1), rsp_avail < 8);
        sent++;
      end else cyc(1'b0, '0, rsp_avail < 8);
      k++;
    end
    chk("dbid_cnt", 128'(seen_dbid.size()), 128'(4097));
    if (seen_dbid.size() == 4097) begin
      chk("dbid_first", 128'(seen_dbid[0]), 128'(12'h000));
      chk("dbid_max", 128'(seen_dbid[4095]), 128'(12'hFFF));
      chk("dbid_wrap", 128'(seen_dbid[4096]), 128'(12'h000));
    end
    repeat (4) cyc(1'b0, '0, 1'b0);
    v_cnt = 0; lc_cnt = 0;
    cyc(1'b1, mkreq(7'h00, 11'd8, 12'h123, 4'h0, 11'd1), 1'b0);
    repeat (4) cyc(1'b0, '0, 1'b0);
    chk("ret_lcrd", 128'(lc_cnt), 128'(1));
    chk("ret_no_rsp", 128'(v_cnt), 128'(0));
    chk("ret_crd", 128'(crd_held), 128'(DEPTH));

    // Randomized traffic against the scoreboard.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit fv, rc;
      logic [6:0] op;
      int pick;
      pick = int'($urandom_range(0, 9));
      if (pick == 0)      op = 7'h00;
      else if (pick < 5)  op = 7'h18 + 7'($urandom_range(0, 7));
      else                op = 7'($urandom_range(1, 127));
      fv = (crd_held > 0) && ($urandom_range(0, 2) != 0);
      rc = (rsp_avail < 14) && ($urandom_range(0, 1) == 1);
      f = mkreq(op, 11'($urandom()), 12'($urandom()), 4'($urandom()),
                ($urandom_range(0, 3) == 0) ? 11'd3 : 11'd1);
      cyc(fv, f, rc);
    end
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin cyc(1'b0, '0, rsp_avail < 14); k++; end
    chk("rand_drained", 128'(exp_q.size()), 128'(0));
    repeat (6) cyc(1'b0, '0, 1'b0);
    chk("rand_crd", 128'(crd_held), 128'(DEPTH));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
